// File: rtl/enc_tx_sched.sv
// TX sequencing controller: buffers link-layer bytes, drives the 8b/10b encoder
// load/emit strobes and paces the serializer one bit per clock with training/fill.
module enc_tx_sched #(
    parameter int         SYM_BITS   = 10,
    parameter int         FIFO_DEPTH = 4,
    parameter int         TRAIN_SYMS = 16,
    parameter logic [7:0] FILL_BYTE  = 8'hBC
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          tx_enable,
    input  logic [7:0]                    s_data,
    input  logic                          s_valid,
    output logic                          s_ready,
    output logic [7:0]                    enc_data,
    output logic                          enc_ser_en,
    output logic                          ser_load,
    output logic                          ser_shift,
    output logic [3:0]                    bit_idx,
    output logic                          sym_is_data,
    output logic                          link_up,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = $clog2(TRAIN_SYMS + 1);

    typedef enum logic [1:0] {IDLE, LOAD, EMIT, SHIFT} state_t;

    state_t          state_reg;
    logic [7:0]      mem [FIFO_DEPTH];
    logic [PW-1:0]   wr_ptr_reg, rd_ptr_reg;
    logic [PW:0]     level_reg;
    logic [CW-1:0]   train_cnt_reg;
    logic [7:0]      enc_data_reg;
    logic [3:0]      bit_idx_reg;
    logic            enc_ser_en_reg, ser_load_reg, ser_shift_reg;
    logic            sym_is_data_reg, link_up_reg;

    logic push, pop, empty, full, last_bit, fill_train, train_done;
    logic link_up_next, take_data;

    assign full       = (level_reg == (PW+1)'(FIFO_DEPTH));
    assign empty      = (level_reg == '0);
    assign s_ready    = !full && !rst;
    assign push       = s_valid && s_ready;
    // The byte chosen at LOAD entry leaves the FIFO at the end of the LOAD cycle.
    assign pop        = (state_reg == LOAD) && sym_is_data_reg;
    assign last_bit   = (state_reg == SHIFT) && (bit_idx_reg == 4'(SYM_BITS - 1));
    assign fill_train = last_bit && !link_up_reg && !sym_is_data_reg;
    assign train_done = fill_train && (train_cnt_reg == CW'(TRAIN_SYMS - 1));
    // Selection for the next LOAD sees link_up as it will be during that LOAD.
    assign link_up_next = link_up_reg || train_done;
    assign take_data    = link_up_next && !empty;

    assign enc_data    = enc_data_reg;
    assign enc_ser_en  = enc_ser_en_reg;
    assign ser_load    = ser_load_reg;
    assign ser_shift   = ser_shift_reg;
    assign bit_idx     = bit_idx_reg;
    assign sym_is_data = sym_is_data_reg;
    assign link_up     = link_up_reg;
    assign fifo_level  = level_reg;

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr_reg] <= s_data;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg       <= IDLE;
            wr_ptr_reg      <= '0;
            rd_ptr_reg      <= '0;
            level_reg       <= '0;
            train_cnt_reg   <= '0;
            enc_data_reg    <= 8'h00;
            enc_ser_en_reg  <= 1'b0;
            ser_load_reg    <= 1'b0;
            ser_shift_reg   <= 1'b0;
            bit_idx_reg     <= 4'd0;
            sym_is_data_reg <= 1'b0;
            link_up_reg     <= 1'b0;
        end else begin
            if (push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
            if (pop)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
            case ({push, pop})
                2'b10:   level_reg <= level_reg + 1'b1;
                2'b01:   level_reg <= level_reg - 1'b1;
                default: ;
            endcase

            case (state_reg)
                IDLE: begin
                    if (tx_enable) begin
                        state_reg       <= LOAD;
                        enc_ser_en_reg  <= 1'b1;
                        enc_data_reg    <= FILL_BYTE;
                        sym_is_data_reg <= 1'b0;
                        link_up_reg     <= 1'b0;
                        train_cnt_reg   <= '0;
                    end
                end
                LOAD: begin
                    state_reg      <= EMIT;
                    enc_ser_en_reg <= 1'b0;
                end
                EMIT: begin
                    state_reg     <= SHIFT;
                    ser_shift_reg <= 1'b1;
                    ser_load_reg  <= 1'b1;
                    bit_idx_reg   <= 4'd0;
                end
                SHIFT: begin
                    ser_load_reg <= 1'b0;
                    if (!last_bit) begin
                        bit_idx_reg <= bit_idx_reg + 4'd1;
                    end else begin
                        if (fill_train) train_cnt_reg <= train_cnt_reg + 1'b1;
                        ser_shift_reg <= 1'b0;
                        bit_idx_reg   <= 4'd0;
                        if (tx_enable) begin
                            state_reg       <= LOAD;
                            enc_ser_en_reg  <= 1'b1;
                            enc_data_reg    <= take_data ? mem[rd_ptr_reg] : FILL_BYTE;
                            sym_is_data_reg <= take_data;
                            link_up_reg     <= link_up_next;
                        end else begin
                            state_reg       <= IDLE;
                            sym_is_data_reg <= 1'b0;
                            link_up_reg     <= 1'b0;
                        end
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_enc_tx_sched.sv
// Directed bench for enc_tx_sched: training, data ordering, backpressure,
// mid-symbol disable and reset abort, all with hand-computed cycle positions.
module tb_enc_tx_sched;
    logic       clk = 1'b0;
    logic       rst, tx_enable, s_valid, s_ready;
    logic [7:0] s_data, enc_data;
    logic       enc_ser_en, ser_load, ser_shift, sym_is_data, link_up;
    logic [3:0] bit_idx;
    logic [2:0] fifo_level;

    always #5 clk = ~clk;

    enc_tx_sched dut (
        .clk(clk), .rst(rst), .tx_enable(tx_enable),
        .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready),
        .enc_data(enc_data), .enc_ser_en(enc_ser_en), .ser_load(ser_load),
        .ser_shift(ser_shift), .bit_idx(bit_idx), .sym_is_data(sym_is_data),
        .link_up(link_up), .fifo_level(fifo_level)
    );

    int vectors = 0;
    int miscompares = 0;
    int cycle = 0;
    int load_age = 99;
    int t0, t2;
    logic [7:0] src_q[$];
    logic [7:0] sb_q[$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h (cycle %0d)", tag, obs, exp, cycle);
        end
    endtask

    task automatic drive_src();
        s_valid = (src_q.size() != 0);
        s_data  = s_valid ? src_q[0] : 8'h00;
    endtask

    task automatic send(input logic [7:0] b);
        src_q.push_back(b);
        drive_src();
    endtask

    // One clock: account for the source handshake, then check latency and byte order.
    task automatic step();
        logic xfer, was_rst;
        xfer    = s_valid && s_ready;
        was_rst = rst;
        @(posedge clk);
        #1;
        cycle++;
        if (was_rst) sb_q.delete();
        else if (xfer) sb_q.push_back(src_q.pop_front());
        drive_src();
        if (enc_ser_en) load_age = 0;
        else load_age++;
        if (ser_load) chk("ser_load_latency", 32'(load_age), 32'd2);
        if (enc_ser_en && sym_is_data) begin
            chk("sb_nonempty", 32'(sb_q.size() != 0), 32'd1);
            if (sb_q.size() != 0) chk("data_order", enc_data, sb_q.pop_front());
            $display("cycle %0d: data symbol %02h level %0d", cycle, enc_data, fifo_level);
        end
    endtask

    task automatic run_until(input int c);
        while (cycle < c) step();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; tx_enable = 1'b0; s_valid = 1'b0; s_data = 8'h00;
        repeat (3) step();
        chk("rst_s_ready", s_ready, 0);
        chk("rst_enc_data", enc_data, 8'h00);
        chk("rst_enc_ser_en", enc_ser_en, 0);
        chk("rst_ser_shift", ser_shift, 0);
        chk("rst_ser_load", ser_load, 0);
        chk("rst_bit_idx", bit_idx, 0);
        chk("rst_link_up", link_up, 0);
        chk("rst_level", fifo_level, 0);
        rst = 1'b0;
        step();
        chk("idle_s_ready", s_ready, 1);
        chk("idle_ser_en", enc_ser_en, 0);

        // Training with an empty FIFO: fill every 12 cycles, link_up after 16 symbols.
        tx_enable = 1'b1;
        step();
        t0 = cycle;
        chk("first_load", enc_ser_en, 1);
        while (cycle < t0 + 192) begin
            chk("train_ser_en", enc_ser_en, 32'(((cycle - t0) % 12) == 0));
            chk("train_link_up", link_up, 0);
            chk("train_sym_is_data", sym_is_data, 0);
            if (enc_ser_en) chk("train_fill", enc_data, 8'hBC);
            step();
        end
        chk("link_up_rise", link_up, 1);
        chk("post_train_load", enc_ser_en, 1);
        chk("post_train_fill", enc_data, 8'hBC);

        // Three back-to-back data symbols, then fill resumes.
        send(8'h00); send(8'h1F); send(8'hE5);
        run_until(t0 + 204);
        chk("d0_level", fifo_level, 3);
        chk("d0_data", enc_data, 8'h00);
        chk("d0_is_data", sym_is_data, 1);
        run_until(t0 + 206);
        chk("d0_ser_load", ser_load, 1);
        chk("d0_is_data_at_load", sym_is_data, 1);
        run_until(t0 + 216);
        chk("d1_data", enc_data, 8'h1F);
        run_until(t0 + 228);
        chk("d2_data", enc_data, 8'hE5);
        run_until(t0 + 240);
        chk("fill_resume_data", enc_data, 8'hBC);
        chk("fill_resume_is_data", sym_is_data, 0);

        // Drop tx_enable at bit 3: symbol completes, then IDLE.
        run_until(t0 + 245);
        chk("dis_bit3", bit_idx, 3);
        tx_enable = 1'b0;
        run_until(t0 + 251);
        chk("dis_bit9", bit_idx, 9);
        chk("dis_shift9", ser_shift, 1);
        step();
        chk("dis_idle_shift", ser_shift, 0);
        chk("dis_idle_ser_en", enc_ser_en, 0);
        chk("dis_idle_link", link_up, 0);

        // Five bytes while idle: four accepted, fifth held by the source.
        send(8'hA1); send(8'hA2); send(8'hA3); send(8'hA4); send(8'hA5);
        run_until(t0 + 260);
        chk("full_level", fifo_level, 4);
        chk("full_s_ready", s_ready, 0);
        chk("full_src_held", 32'(src_q.size()), 1);

        // Re-enable: retrain before retained bytes go out.
        tx_enable = 1'b1;
        step();
        t2 = cycle;
        chk("re_load", enc_ser_en, 1);
        chk("re_fill", enc_data, 8'hBC);
        chk("re_link_down", link_up, 0);
        run_until(t2 + 191);
        chk("re_train_level", fifo_level, 4);
        chk("re_train_link", link_up, 0);
        step();
        chk("re_link_up", link_up, 1);
        chk("re_first_data", enc_data, 8'hA1);
        chk("re_first_is_data", sym_is_data, 1);
        chk("re_load_level", fifo_level, 4);
        step();
        chk("re_pop_level", fifo_level, 3);
        chk("re_pop_ready", s_ready, 1);
        step();
        chk("re_fifth_level", fifo_level, 4);
        run_until(t2 + 204);
        chk("re_a2", enc_data, 8'hA2);
        run_until(t2 + 240);
        chk("re_a5", enc_data, 8'hA5);

        // Push and pop together at level 2, then ten bytes through the wrapping pointers.
        step();
        send(8'hB0); send(8'hB1);
        run_until(t2 + 252);
        chk("pp_level_load", fifo_level, 2);
        chk("pp_b0", enc_data, 8'hB0);
        send(8'hB2);
        step();
        chk("pp_level_after", fifo_level, 2);
        for (int i = 3; i < 10; i++) send(8'hB0 + 8'(i));
        run_until(t2 + 360);
        chk("wrap_b9", enc_data, 8'hB9);
        run_until(t2 + 372);
        chk("wrap_fill", enc_data, 8'hBC);
        chk("wrap_fill_is_data", sym_is_data, 0);
        chk("wrap_level", fifo_level, 0);
        chk("wrap_sb_drained", 32'(sb_q.size()), 0);

        // Reset mid-symbol at bit 5 aborts everything.
        send(8'hC0); send(8'hC1);
        run_until(t2 + 379);
        chk("abort_bit5", bit_idx, 5);
        chk("abort_level_pre", fifo_level, 2);
        rst = 1'b1;
        step();
        chk("abort_shift", ser_shift, 0);
        chk("abort_bit_idx", bit_idx, 0);
        chk("abort_enc_data", enc_data, 8'h00);
        chk("abort_ser_en", enc_ser_en, 0);
        chk("abort_ser_load", ser_load, 0);
        chk("abort_is_data", sym_is_data, 0);
        chk("abort_link", link_up, 0);
        chk("abort_level", fifo_level, 0);
        chk("abort_s_ready", s_ready, 0);
        step();
        chk("abort_shift_hold", ser_shift, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
